panel_serial_io: RTL and testbench

Panel-side serial engine inside `soc_top`. It shifts 64 bits of panel display state (op code, STRT, SEL, register C) out to four cascaded 74LV595 chains. In the same frame it parallel-loads and shifts in 64 bits of switch state from four cascaded 74LV165 chains. Each chain is 16 bits, built from two 8-bit chips. It is the controller end of the `serial_out_*` / `serial_in_*` pins.

---
 rtl/panel_serial_io.sv | 167 ++++++++++++++++
 tb/tb_panel_serial_io.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/panel_serial_io.sv
`default_nettype none
// ============================================================================
// panel_serial_io : frames 64 display bits out to four 74LV595 chains and
// 64 switch bits in from four 74LV165 chains (16 bits per chain).
// Optional macro PANEL_SERIAL_AUTO_EN: continuous refresh, xfer_req ignored.
// Revision: 1.0
// ============================================================================
module panel_serial_io #(
   parameter int CLK_DIV = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        xfer_req,
   input  logic [63:0] out_data,
   output logic        xfer_busy,
   output logic        in_valid,
   output logic [63:0] in_data,
   output logic        serial_out_srclk,
   output logic        serial_out_rclk,
   output logic        serial_out_ser_0,
   output logic        serial_out_ser_1,
   output logic        serial_out_ser_2,
   output logic        serial_out_ser_3,
   output logic        serial_in_rclk,
   output logic        serial_in_shldn,
   input  logic        serial_in_ser_0,
   input  logic        serial_in_ser_1,
   input  logic        serial_in_ser_2,
   input  logic        serial_in_ser_3
);

   localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD     = 3'd1,
      SHIFT_LO = 3'd2,
      SHIFT_HI = 3'd3,
      LATCH_HI = 3'd4,
      LATCH_LO = 3'd5,
      DONE     = 3'd6
   } state_t;

   state_t           state, state_nx;
   logic [DIV_W-1:0] div_cnt, div_nx;
   logic [3:0]       bit_cnt, bit_nx;
   logic [63:0]      out_sr, out_sr_nx;
   logic [63:0]      cap_sr, cap_nx;
   logic [3:0]       ser, ser_nx;
   logic [3:0]       ser_in;
   logic             start;
   logic             phase_end;

`ifdef PANEL_SERIAL_AUTO_EN
   logic unused_xfer_req;
   assign unused_xfer_req = xfer_req;
   assign start           = 1'b1;
`else
   assign start = xfer_req;
`endif

   assign ser_in           = {serial_in_ser_3, serial_in_ser_2, serial_in_ser_1, serial_in_ser_0};
   assign serial_out_ser_0 = ser[0];
   assign serial_out_ser_1 = ser[1];
   assign serial_out_ser_2 = ser[2];
   assign serial_out_ser_3 = ser[3];
   assign phase_end        = (div_cnt == DIV_LAST);

   always_comb begin
      state_nx  = state;
      div_nx    = div_cnt;
      bit_nx    = bit_cnt;
      out_sr_nx = out_sr;
      cap_nx    = cap_sr;
      ser_nx    = 4'd0;

      if (state != IDLE && state != DONE) begin
         div_nx = phase_end ? '0 : div_cnt + 1'b1;
      end

      case (state)
         IDLE: begin
            if (start) begin
               state_nx  = LOAD;
               div_nx    = '0;
               bit_nx    = 4'hF;
               out_sr_nx = out_data;
            end
         end
         LOAD: begin
            if (phase_end) state_nx = SHIFT_LO;
         end
         SHIFT_LO: begin
            // Sample QH just before the shift edge; chains fill MSB first.
            if (phase_end) begin
               state_nx = SHIFT_HI;
               for (int n = 0; n < 4; n++) begin
                  cap_nx[16*n +: 16] = {cap_sr[16*n +: 15], ser_in[n]};
               end
            end
         end
         SHIFT_HI: begin
            if (phase_end) begin
               if (bit_cnt == 4'd0) begin
                  state_nx = LATCH_HI;
               end else begin
                  state_nx = SHIFT_LO;
                  bit_nx   = bit_cnt - 4'd1;
                  for (int n = 0; n < 4; n++) begin
                     out_sr_nx[16*n +: 16] = {out_sr[16*n +: 15], 1'b0};
                  end
               end
            end
         end
         LATCH_HI: begin
            if (phase_end) state_nx = LATCH_LO;
         end
         LATCH_LO: begin
            if (phase_end) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase

      // Chain MSBs of the (possibly just shifted) register drive the 595 data pins.
      if (state_nx == SHIFT_LO || state_nx == SHIFT_HI) begin
         for (int n = 0; n < 4; n++) begin
            ser_nx[n] = out_sr_nx[16*n + 15];
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state            <= IDLE;
         div_cnt          <= '0;
         bit_cnt          <= 4'd0;
         out_sr           <= 64'd0;
         cap_sr           <= 64'd0;
         ser              <= 4'd0;
         xfer_busy        <= 1'b0;
         in_valid         <= 1'b0;
         in_data          <= 64'd0;
         serial_out_srclk <= 1'b0;
         serial_out_rclk  <= 1'b0;
         serial_in_rclk   <= 1'b0;
         serial_in_shldn  <= 1'b1;
      end else begin
         state            <= state_nx;
         div_cnt          <= div_nx;
         bit_cnt          <= bit_nx;
         out_sr           <= out_sr_nx;
         cap_sr           <= cap_nx;
         ser              <= ser_nx;
         xfer_busy        <= (state_nx != IDLE);
         in_valid         <= (state_nx == DONE);
         serial_out_srclk <= (state_nx == SHIFT_HI);
         serial_in_rclk   <= (state_nx == SHIFT_HI);
         serial_out_rclk  <= (state_nx == LATCH_HI);
         serial_in_shldn  <= (state_nx != LOAD);
         if (state_nx == DONE) in_data <= cap_sr;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_panel_serial_io.sv
`default_nettype none
// tb_panel_serial_io : three DUTs (CLK_DIV 4, 1, 3) driving 595/165 chain models,
// frame-position reference model plus an in_valid scoreboard per instance.
module tb_panel_serial_io;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit inst_done [3];

`ifdef PANEL_SERIAL_AUTO_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   typedef struct {
      logic [63:0] dout;
      logic [63:0] din;
      int          done_cyc;
   } frame_t;

   task automatic chk(input string nm, input int h, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (CLK_DIV=%0d) at %0t: got %h, expected %h", nm, h, $time, act, exp);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_inst
      localparam int H  = (g == 0) ? 4 : (g == 1) ? 1 : 3;
      localparam int FL = 35 * H;
      localparam int TR = (H == 1) ? 20 : 50;

      logic        resetn, xfer_req, xfer_busy, in_valid;
      logic        srclk, rclk, sirclk, shldn;
      logic [63:0] out_data, in_data, sw;
      logic [3:0]  ser_o, ser_i;
      logic [63:0] q595;

      int          cyc      = 0;
      int          m_free   = 0;
      int          m_E      = 0;
      bit          m_active = 1'b0;
      logic [63:0] m_out    = '0;
      logic [63:0] m_sw     = '0;
      logic [63:0] m_q595   = '0;
      logic [63:0] m_in     = '0;
      frame_t      sb [$];

      panel_serial_io #(.CLK_DIV(H)) u_dut (
         .clk              (clk),
         .resetn           (resetn),
         .xfer_req         (xfer_req),
         .out_data         (out_data),
         .xfer_busy        (xfer_busy),
         .in_valid         (in_valid),
         .in_data          (in_data),
         .serial_out_srclk (srclk),
         .serial_out_rclk  (rclk),
         .serial_out_ser_0 (ser_o[0]),
         .serial_out_ser_1 (ser_o[1]),
         .serial_out_ser_2 (ser_o[2]),
         .serial_out_ser_3 (ser_o[3]),
         .serial_in_rclk   (sirclk),
         .serial_in_shldn  (shldn),
         .serial_in_ser_0  (ser_i[0]),
         .serial_in_ser_1  (ser_i[1]),
         .serial_in_ser_2  (ser_i[2]),
         .serial_in_ser_3  (ser_i[3])
      );

      // Two cascaded chips per chain behave as one 16-bit register.
      for (genvar n = 0; n < 4; n++) begin : g_chain
         logic [15:0] s595 = '0;
         logic [15:0] q    = '0;
         logic [15:0] s165 = '0;
         always @(posedge srclk) s595 <= {s595[14:0], ser_o[n]};
         always @(posedge rclk)  q    <= s595;
         always @(posedge sirclk or negedge shldn) begin
            if (!shldn) s165 <= sw[16*n +: 16];
            else        s165 <= {s165[14:0], 1'b0};
         end
         assign ser_i[n]           = s165[15];
         assign q595[16*n +: 16]   = q;
      end

      // Reference model: decides acceptance edges from the request rules.
      initial begin
         frame_t f;
         forever begin
            @(posedge clk);
            cyc++;
            if (resetn === 1'b1 && cyc >= m_free && (xfer_req === 1'b1 || AUTO)) begin
               m_active   = 1'b1;
               m_E        = cyc;
               m_out      = out_data;
               m_sw       = sw;
               m_free     = cyc + FL + 2;
               f.dout     = out_data;
               f.din      = sw;
               f.done_cyc = cyc + FL;
               sb.push_back(f);
            end
         end
      end

      // Cycle checker: expected pin levels from position t within the frame.
      initial begin
         int         t;
         int         k;
         bit         in_f;
         bit         hi;
         logic [5:0] exp_ctl;
         logic [3:0] exp_ser;
         forever begin
            @(negedge clk);
            #1;
            t    = cyc - m_E;
            in_f = m_active && t <= FL;
            hi   = in_f && t >= H && t < 33*H && (((t - H) / H) % 2 == 1);
            if (in_f && t == 33*H) m_q595 = m_out;
            if (in_f && t == FL)   m_in   = m_sw;
            exp_ctl = {in_f, !(in_f && t < H), hi, hi, in_f && t >= 33*H && t < 34*H, in_f && t == FL};
            chk("ctl{busy,shldn,srclk,in_rclk,rclk,in_valid}", H,
                64'({xfer_busy, shldn, srclk, sirclk, rclk, in_valid}), 64'(exp_ctl));
            chk("in_data", H, in_data, m_in);
            chk("595_outputs", H, q595, m_q595);
            if (in_f && t >= H && t < 33*H && !hi) begin
               k = 15 - (t - H) / (2*H);
               for (int n = 0; n < 4; n++) exp_ser[n] = m_out[16*n + k];
               chk("ser_bits", H, 64'(ser_o), 64'(exp_ser));
            end
         end
      end

      // Scoreboard monitor: pops one expected frame per in_valid pulse.
      initial begin
         frame_t f;
         forever begin
            @(negedge clk);
            #1;
            if (in_valid === 1'b1) begin
               if (sb.size() == 0) begin
                  chk("pending_frames_at_valid", H, 64'(sb.size()), 64'd1);
               end else begin
                  f = sb.pop_front();
                  chk("valid_cycle", H, 64'(cyc), 64'(f.done_cyc));
                  chk("in_data_at_valid", H, in_data, f.din);
                  chk("595_at_valid", H, q595, f.dout);
               end
            end
         end
      end

      task automatic pulse_req();
         xfer_req = 1'b1;
         @(negedge clk);
         xfer_req = 1'b0;
      endtask

      task automatic wait_frame_end();
         int tgt;
         tgt = m_E + FL + 1;
         while (cyc < tgt) @(negedge clk);
      endtask

      initial begin
         int e0;
         resetn   = 1'b0;
         xfer_req = 1'b0;
         out_data = '0;
         sw       = '0;
         repeat (3) @(negedge clk);
         resetn = 1'b1;
         @(negedge clk);

         out_data = 64'h0123_4567_89AB_CDEF;
         sw       = 64'h0000_A5A5_7FFE_8001;
         pulse_req();
         wait_frame_end();

         repeat (6) begin
            out_data = {$urandom, $urandom};
            sw       = {$urandom, $urandom};
            pulse_req();
            repeat ($urandom_range(2, FL - 2)) @(negedge clk);
            out_data = {$urandom, $urandom};
            pulse_req();
            wait_frame_end();
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end

         xfer_req = 1'b1;
         repeat (4) begin
            e0 = m_E;
            repeat ($urandom_range(2*H, 25*H)) @(negedge clk);
            out_data = {$urandom, $urandom};
            sw       = {$urandom, $urandom};
            while (m_E == e0) @(negedge clk);
         end
         xfer_req = 1'b0;
         wait_frame_end();
         @(negedge clk);

         out_data = {$urandom, $urandom};
         sw       = {$urandom, $urandom};
         pulse_req();
         while (cyc < m_E + TR) @(negedge clk);
         resetn   = 1'b0;
         m_active = 1'b0;
         m_in     = '0;
         m_free   = 0;
         sb.delete();
         repeat (3) @(negedge clk);
         resetn = 1'b1;
         @(negedge clk);

         out_data = {$urandom, $urandom};
         sw       = {$urandom, $urandom};
         pulse_req();
         wait_frame_end();
         repeat (2) @(negedge clk);
         chk("scoreboard_drained", H, 64'(sb.size()), 64'd0);
         inst_done[g] = 1'b1;
      end
   end

   initial begin
      int guard;
      guard = 0;
      while (!(inst_done[0] && inst_done[1] && inst_done[2]) && guard < 40000) begin
         @(posedge clk);
         guard++;
      end
      if (guard >= 40000) begin
         chk("instances_finished", 0, 64'({inst_done[2], inst_done[1], inst_done[0]}), 64'h7);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
